// File: rtl/prbs_frame_tx.sv
// Transmit-side framer for the FEC loopback link: emits sync word, header and PRBS-31
// payload frames on a registered valid/ready stream, with one-shot bit-0 error injection.
module prbs_frame_tx #(
  parameter int unsigned W                = 32,
  parameter int unsigned PAYLOAD_WORDS    = 16,
  parameter int unsigned FRAMES_PER_BLOCK = 255,
  parameter int unsigned GAP_WORDS        = 0,
  parameter logic [31:0] SYNC_WORD        = 32'h1ACFFC1D,
  parameter logic [30:0] PRBS_SEED        = 31'h7FFFFFFF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         err_inj,
  output logic [W-1:0] tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         tx_sof,
  output logic         tx_eof,
  output logic         tx_sob,
  output logic [31:0]  frames_sent,
  output logic [15:0]  errs_injected,
  output logic         busy
);

  localparam int unsigned IDX_W = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1;
  localparam int unsigned GAP_W = (GAP_WORDS > 1) ? $clog2(GAP_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_WORDS - 1);
  localparam logic [IDX_W-1:0] PRE_LAST = IDX_W'((PAYLOAD_WORDS > 1) ? PAYLOAD_WORDS - 2 : 0);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_WORDS > 0) ? GAP_WORDS - 1 : 0);
  localparam logic [15:0]      FIB_LAST = 16'(FRAMES_PER_BLOCK - 1);
  // an all-zero seed would lock the LFSR, so it is replaced by all-ones
  localparam logic [30:0]      SEED_EFF = (PRBS_SEED == 31'd0) ? 31'h7FFFFFFF : PRBS_SEED;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC    = 3'd1,
    ST_HDR     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_GAP     = 3'd4
  } state_t;

  // Next W PRBS-31 bits (x^31+x^28+1), MSB first; the last 31 bits are the advanced LFSR state.
  function automatic logic [W-1:0] prbs_word(input logic [30:0] seed);
    logic [30:0]  s;
    logic         fb;
    logic [W-1:0] w;
    s = seed;
    w = {W{1'b0}};
    for (int i = W - 1; i >= 0; i--) begin
      fb   = s[30] ^ s[27];
      w[i] = fb;
      s    = {s[29:0], fb};
    end
    return w;
  endfunction

  state_t           state_r, state_nxt;
  logic [IDX_W-1:0] idx_r, idx_nxt;
  logic [GAP_W-1:0] gap_cnt_r, gap_cnt_nxt;
  logic [30:0]      lfsr_r, lfsr_nxt;
  logic [15:0]      frame_seq_r, frame_seq_nxt;
  logic [15:0]      fib_r, fib_nxt;
  logic             err_pending_r, err_pending_nxt;
  logic             err_flag_r, err_flag_nxt;
  logic [W-1:0]     tx_data_r, tx_data_nxt;
  logic             tx_valid_r, tx_valid_nxt;
  logic             tx_sof_r, tx_sof_nxt;
  logic             tx_eof_r, tx_eof_nxt;
  logic             tx_sob_r, tx_sob_nxt;
  logic [31:0]      frames_r, frames_nxt;
  logic [15:0]      errs_r, errs_nxt;
  logic             busy_r, busy_nxt;

  logic             xfer_s;
  logic             flip_s;
  logic [W-1:0]     cur_word_s;
  logic [W-1:0]     nxt_word_s;
  logic [W-1:0]     flip_mask_s;
  logic [15:0]      fib_inc_s;

  assign xfer_s      = tx_valid_r & tx_ready;
  assign flip_s      = err_pending_r | err_inj;
  assign flip_mask_s = {{(W - 1){1'b0}}, flip_s};
  // cur_word_s is the clean form of the payload word at lfsr_r; nxt_word_s is the one after it
  assign cur_word_s  = prbs_word(lfsr_r);
  assign nxt_word_s  = prbs_word(cur_word_s[30:0]);
  assign fib_inc_s   = (fib_r == FIB_LAST) ? 16'd0 : fib_r + 16'd1;

  // Next-state and next-output logic for the framing FSM.
  always_comb begin
    state_nxt       = state_r;
    idx_nxt         = idx_r;
    gap_cnt_nxt     = gap_cnt_r;
    lfsr_nxt        = lfsr_r;
    frame_seq_nxt   = frame_seq_r;
    fib_nxt         = fib_r;
    err_pending_nxt = err_pending_r | err_inj;
    err_flag_nxt    = err_flag_r;
    tx_data_nxt     = tx_data_r;
    tx_valid_nxt    = tx_valid_r;
    tx_sof_nxt      = tx_sof_r;
    tx_eof_nxt      = tx_eof_r;
    tx_sob_nxt      = tx_sob_r;
    frames_nxt      = frames_r;
    errs_nxt        = errs_r;

    case (state_r)
      ST_IDLE: begin
        tx_valid_nxt = 1'b0;
        tx_data_nxt  = {W{1'b0}};
        tx_sof_nxt   = 1'b0;
        tx_eof_nxt   = 1'b0;
        tx_sob_nxt   = 1'b0;
        if (en) begin
          state_nxt    = ST_SYNC;
          tx_valid_nxt = 1'b1;
          tx_data_nxt  = SYNC_WORD;
          tx_sof_nxt   = 1'b1;
          tx_sob_nxt   = (fib_r == 16'd0);
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SYNC: begin
        if (xfer_s) begin
          state_nxt   = ST_HDR;
          tx_data_nxt = {8'hA5, fib_r[7:0], frame_seq_r};
          tx_sof_nxt  = 1'b0;
          tx_sob_nxt  = 1'b0;
        end else begin
          state_nxt = ST_SYNC;
        end
      end
      ST_HDR: begin
        if (xfer_s) begin
          state_nxt    = ST_PAYLOAD;
          idx_nxt      = {IDX_W{1'b0}};
          tx_data_nxt  = cur_word_s ^ flip_mask_s;
          err_flag_nxt = flip_s;
          tx_eof_nxt   = (PAYLOAD_WORDS == 1);
          if (flip_s) begin
            err_pending_nxt = 1'b0;
          end else begin
            err_pending_nxt = err_pending_r;
          end
        end else begin
          state_nxt = ST_HDR;
        end
      end
      ST_PAYLOAD: begin
        if (xfer_s) begin
          lfsr_nxt = cur_word_s[30:0];
          if (err_flag_r) begin
            errs_nxt = (errs_r == 16'hFFFF) ? errs_r : errs_r + 16'd1;
          end else begin
            errs_nxt = errs_r;
          end
          if (idx_r == LAST_IDX) begin
            frames_nxt    = frames_r + 32'd1;
            frame_seq_nxt = frame_seq_r + 16'd1;
            fib_nxt       = fib_inc_s;
            err_flag_nxt  = 1'b0;
            tx_eof_nxt    = 1'b0;
            if (GAP_WORDS > 0) begin
              state_nxt    = ST_GAP;
              gap_cnt_nxt  = {GAP_W{1'b0}};
              tx_valid_nxt = 1'b0;
              tx_data_nxt  = {W{1'b0}};
            end else if (en) begin
              state_nxt   = ST_SYNC;
              tx_data_nxt = SYNC_WORD;
              tx_sof_nxt  = 1'b1;
              tx_sob_nxt  = (fib_inc_s == 16'd0);
            end else begin
              state_nxt    = ST_IDLE;
              tx_valid_nxt = 1'b0;
              tx_data_nxt  = {W{1'b0}};
            end
          end else begin
            idx_nxt      = idx_r + {{(IDX_W - 1){1'b0}}, 1'b1};
            tx_data_nxt  = nxt_word_s ^ flip_mask_s;
            err_flag_nxt = flip_s;
            tx_eof_nxt   = (idx_r == PRE_LAST);
            if (flip_s) begin
              err_pending_nxt = 1'b0;
            end else begin
              err_pending_nxt = err_pending_r;
            end
          end
        end else begin
          state_nxt = ST_PAYLOAD;
        end
      end
      ST_GAP: begin
        tx_valid_nxt = 1'b0;
        if (gap_cnt_r == GAP_LAST) begin
          if (en) begin
            state_nxt    = ST_SYNC;
            tx_valid_nxt = 1'b1;
            tx_data_nxt  = SYNC_WORD;
            tx_sof_nxt   = 1'b1;
            tx_sob_nxt   = (fib_r == 16'd0);
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          gap_cnt_nxt = gap_cnt_r + {{(GAP_W - 1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_nxt    = ST_IDLE;
        tx_valid_nxt = 1'b0;
        tx_data_nxt  = {W{1'b0}};
        tx_sof_nxt   = 1'b0;
        tx_eof_nxt   = 1'b0;
        tx_sob_nxt   = 1'b0;
      end
    endcase

    busy_nxt = (state_nxt != ST_IDLE);
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      idx_r         <= {IDX_W{1'b0}};
      gap_cnt_r     <= {GAP_W{1'b0}};
      lfsr_r        <= SEED_EFF;
      frame_seq_r   <= 16'd0;
      fib_r         <= 16'd0;
      err_pending_r <= 1'b0;
      err_flag_r    <= 1'b0;
      tx_data_r     <= {W{1'b0}};
      tx_valid_r    <= 1'b0;
      tx_sof_r      <= 1'b0;
      tx_eof_r      <= 1'b0;
      tx_sob_r      <= 1'b0;
      frames_r      <= 32'd0;
      errs_r        <= 16'd0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_nxt;
      idx_r         <= idx_nxt;
      gap_cnt_r     <= gap_cnt_nxt;
      lfsr_r        <= lfsr_nxt;
      frame_seq_r   <= frame_seq_nxt;
      fib_r         <= fib_nxt;
      err_pending_r <= err_pending_nxt;
      err_flag_r    <= err_flag_nxt;
      tx_data_r     <= tx_data_nxt;
      tx_valid_r    <= tx_valid_nxt;
      tx_sof_r      <= tx_sof_nxt;
      tx_eof_r      <= tx_eof_nxt;
      tx_sob_r      <= tx_sob_nxt;
      frames_r      <= frames_nxt;
      errs_r        <= errs_nxt;
      busy_r        <= busy_nxt;
    end
  end

  assign tx_data       = tx_data_r;
  assign tx_valid      = tx_valid_r;
  assign tx_sof        = tx_sof_r;
  assign tx_eof        = tx_eof_r;
  assign tx_sob        = tx_sob_r;
  assign frames_sent   = frames_r;
  assign errs_injected = errs_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_prbs_frame_tx.sv
// Self-checking bench for prbs_frame_tx: a PRBS-31 recurrence model feeds an expected-beat
// queue that is popped on every stream transfer; a second instance covers inter-frame gaps.
module tb_prbs_frame_tx;

  localparam logic [31:0] SYNC = 32'h1ACFFC1D;
  localparam logic [30:0] SEED = 31'h7FFFFFFF;
  localparam int          FW   = 18;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, err_inj = 1'b0, tx_ready = 1'b0;
  logic [31:0] tx_data;
  logic        tx_valid, tx_sof, tx_eof, tx_sob, busy;
  logic [31:0] frames_sent;
  logic [15:0] errs_injected;

  logic        en2 = 1'b0, ready2 = 1'b0;
  logic [31:0] tx_data2;
  logic        tx_valid2, tx_sof2, tx_eof2, tx_sob2, busy2;
  logic [31:0] frames_sent2;
  logic [15:0] errs_injected2;

  int checks = 0;
  int errors = 0;

  logic [34:0] exp_q[$];
  bit          hist[$];
  logic [15:0] m_seq, m_fib;

  always #5 clk = ~clk;

  prbs_frame_tx dut (
    .clk(clk), .rst(rst), .en(en), .err_inj(err_inj),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_sof(tx_sof), .tx_eof(tx_eof), .tx_sob(tx_sob),
    .frames_sent(frames_sent), .errs_injected(errs_injected), .busy(busy)
  );

  prbs_frame_tx #(.PAYLOAD_WORDS(4), .GAP_WORDS(3)) dut_gap (
    .clk(clk), .rst(rst), .en(en2), .err_inj(1'b0),
    .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(ready2),
    .tx_sof(tx_sof2), .tx_eof(tx_eof2), .tx_sob(tx_sob2),
    .frames_sent(frames_sent2), .errs_injected(errs_injected2), .busy(busy2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // history queue holds the last 31 sequence bits, oldest first: b[n] = b[n-31] ^ b[n-28]
  task automatic model_reset();
    logic [30:0] sd;
    sd = SEED;
    hist.delete();
    for (int i = 30; i >= 0; i--) hist.push_back(sd[i]);
    m_seq = 16'd0;
    m_fib = 16'd0;
    exp_q.delete();
  endtask

  task automatic model_word(output logic [31:0] w);
    bit b;
    for (int i = 31; i >= 0; i--) begin
      b = hist[0] ^ hist[3];
      w[i] = b;
      hist.push_back(b);
      void'(hist.pop_front());
    end
  endtask

  task automatic model_push_frame(input bit flip_first);
    logic [31:0] w;
    exp_q.push_back({(m_fib == 16'd0), 1'b1, 1'b0, SYNC});
    exp_q.push_back({3'b000, 8'hA5, m_fib[7:0], m_seq});
    for (int k = 0; k < 16; k++) begin
      model_word(w);
      if (k == 0 && flip_first) w[0] = ~w[0];
      exp_q.push_back({1'b0, 1'b0, (k == 15), w});
    end
    m_seq = m_seq + 16'd1;
    m_fib = (m_fib == 16'd254) ? 16'd0 : m_fib + 16'd1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; err_inj = 1'b0; tx_ready = 1'b0; en2 = 1'b0; ready2 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({tx_valid, tx_sof, tx_eof, tx_sob, busy} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 00000", {tx_valid, tx_sof, tx_eof, tx_sob, busy});
    end
    checks++;
    if (tx_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", tx_data); end
    checks++;
    if (frames_sent !== 32'd0 || errs_injected !== 16'd0) begin
      errors++; $display("FAIL reset_counters got %0d/%0d exp 0/0", frames_sent, errs_injected);
    end
    checks++;
    if (tx_valid2 !== 1'b0 || busy2 !== 1'b0) begin
      errors++; $display("FAIL reset_gap_dut got valid=%b busy=%b exp 0/0", tx_valid2, busy2);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int n, cyc;
    logic [34:0] e;
    do_reset();
    model_push_frame(1'b0);
    en = 1'b1; tx_ready = 1'b1;
    tick();
    en = 1'b0;
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 32'h1ACFFC1D || tx_sof !== 1'b1) begin
      errors++; $display("FAIL basic_latency got v=%b d=%h sof=%b exp 1/1acffc1d/1", tx_valid, tx_data, tx_sof);
    end
    n = 0; cyc = 0;
    while (n < FW && cyc < 60) begin
      if (tx_valid && tx_ready) begin
        e = exp_q.pop_front();
        checks++;
        if ({tx_sob, tx_sof, tx_eof, tx_data} !== e) begin
          errors++; $display("FAIL basic_beat%0d got %h exp %h", n, {tx_sob, tx_sof, tx_eof, tx_data}, e);
        end
        n++;
      end
      tick(); cyc++;
    end
    tx_ready = 1'b0;
    checks++;
    if (n != FW) begin errors++; $display("FAIL basic_timeout got %0d beats exp %0d", n, FW); end
    checks++;
    if (frames_sent !== 32'd1) begin errors++; $display("FAIL basic_frames got %0d exp 1", frames_sent); end
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_idle got v=%b busy=%b exp 0/0", tx_valid, busy);
    end
  endtask

  task automatic test_stall();
    int n, cyc;
    logic [34:0] e, held;
    logic stalled;
    do_reset();
    model_push_frame(1'b0);
    en = 1'b1;
    tick();
    en = 1'b0;
    n = 0; cyc = 0; stalled = 1'b0; held = '0;
    while (n < FW && cyc < 400) begin
      tx_ready = 1'($urandom_range(1, 0));
      if (stalled) begin
        checks++;
        if (tx_valid !== 1'b1 || {tx_sob, tx_sof, tx_eof, tx_data} !== held) begin
          errors++; $display("FAIL stall_hold got v=%b %h exp 1 %h", tx_valid, {tx_sob, tx_sof, tx_eof, tx_data}, held);
        end
      end
      stalled = tx_valid && !tx_ready;
      held = {tx_sob, tx_sof, tx_eof, tx_data};
      if (tx_valid && tx_ready) begin
        e = exp_q.pop_front();
        checks++;
        if ({tx_sob, tx_sof, tx_eof, tx_data} !== e) begin
          errors++; $display("FAIL stall_beat%0d got %h exp %h", n, {tx_sob, tx_sof, tx_eof, tx_data}, e);
        end
        n++;
      end
      tick(); cyc++;
    end
    tx_ready = 1'b0;
    checks++;
    if (n != FW) begin errors++; $display("FAIL stall_timeout got %0d beats exp %0d", n, FW); end
  endtask

  task automatic test_block_wrap();
    int n, cyc;
    logic [34:0] e;
    do_reset();
    for (int f = 0; f < 257; f++) model_push_frame(1'b0);
    en = 1'b1; tx_ready = 1'b1;
    n = 0; cyc = 0;
    while (n < 257 * FW && cyc < 257 * FW + 40) begin
      if (n == 256 * FW) en = 1'b0;
      if (tx_valid && tx_ready) begin
        e = exp_q.pop_front();
        checks++;
        if ({tx_sob, tx_sof, tx_eof, tx_data} !== e) begin
          errors++; $display("FAIL wrap_beat%0d got %h exp %h", n, {tx_sob, tx_sof, tx_eof, tx_data}, e);
        end
        if (n == 0 || n == 255 * FW || n == 254 * FW) begin
          checks++;
          if (tx_sob !== (n != 254 * FW)) begin
            errors++; $display("FAIL wrap_sob at beat %0d got %b exp %b", n, tx_sob, (n != 254 * FW));
          end
        end
        if (n == 255 * FW + 1) begin
          checks++;
          if (tx_data !== 32'hA50000FF) begin errors++; $display("FAIL wrap_hdr255 got %h exp a50000ff", tx_data); end
        end
        if (n == 256 * FW + 1) begin
          checks++;
          if (tx_data !== 32'hA5010100) begin errors++; $display("FAIL wrap_hdr256 got %h exp a5010100", tx_data); end
        end
        n++;
      end
      tick(); cyc++;
    end
    tx_ready = 1'b0;
    checks++;
    if (n != 257 * FW || frames_sent !== 32'd257) begin
      errors++; $display("FAIL wrap_count got beats=%0d frames=%0d exp %0d/257", n, frames_sent, 257 * FW);
    end
  endtask

  task automatic test_err_inj();
    int n, cyc;
    logic [34:0] e;
    bit pulsed;
    do_reset();
    model_push_frame(1'b0);
    model_push_frame(1'b0);
    model_push_frame(1'b1);
    model_push_frame(1'b0);
    en = 1'b1; tx_ready = 1'b1;
    n = 0; cyc = 0; pulsed = 1'b0;
    while (n < 4 * FW && cyc < 4 * FW + 40) begin
      if (n == 3 * FW) en = 1'b0;
      if (n == 2 * FW + 1 && !pulsed) begin
        checks++;
        if (errs_injected !== 16'd0) begin errors++; $display("FAIL err_before got %0d exp 0", errs_injected); end
        tx_ready = 1'b0; err_inj = 1'b1;
        tick(); cyc++;
        err_inj = 1'b0; tx_ready = 1'b1; pulsed = 1'b1;
      end
      if (tx_valid && tx_ready) begin
        e = exp_q.pop_front();
        checks++;
        if ({tx_sob, tx_sof, tx_eof, tx_data} !== e) begin
          errors++; $display("FAIL err_beat%0d got %h exp %h", n, {tx_sob, tx_sof, tx_eof, tx_data}, e);
        end
        n++;
      end
      tick(); cyc++;
      if (n == 2 * FW + 3) begin
        checks++;
        if (errs_injected !== 16'd1) begin errors++; $display("FAIL err_count got %0d exp 1", errs_injected); end
      end
    end
    tx_ready = 1'b0;
    checks++;
    if (n != 4 * FW || errs_injected !== 16'd1) begin
      errors++; $display("FAIL err_final got beats=%0d errs=%0d exp %0d/1", n, errs_injected, 4 * FW);
    end
  endtask

  task automatic test_gap();
    int cyc, idle;
    do_reset();
    en2 = 1'b1; ready2 = 1'b1;
    cyc = 0;
    while (!(tx_valid2 && tx_eof2) && cyc < 50) begin tick(); cyc++; end
    tick();
    idle = 0;
    while (!tx_valid2 && idle < 10) begin idle++; tick(); end
    checks++;
    if (idle != 3 || tx_sof2 !== 1'b1 || cyc >= 50) begin
      errors++; $display("FAIL gap_len got idle=%0d sof=%b exp 3/1", idle, tx_sof2);
    end
    tick();
    tick();
    en2 = 1'b0;
    cyc = 0;
    while (!(tx_valid2 && tx_eof2) && cyc < 50) begin tick(); cyc++; end
    tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (tx_valid2 !== 1'b0 || busy2 !== 1'b1) begin
        errors++; $display("FAIL gap_cycle%0d got v=%b busy=%b exp 0/1", k, tx_valid2, busy2);
      end
      tick();
    end
    checks++;
    if (tx_valid2 !== 1'b0 || busy2 !== 1'b0 || frames_sent2 !== 32'd2) begin
      errors++; $display("FAIL gap_idle got v=%b busy=%b frames=%0d exp 0/0/2", tx_valid2, busy2, frames_sent2);
    end
    tick(); tick();
    checks++;
    if (tx_valid2 !== 1'b0) begin errors++; $display("FAIL gap_stays_idle got v=%b exp 0", tx_valid2); end
    ready2 = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n, cyc;
    logic [34:0] e;
    do_reset();
    model_push_frame(1'b0);
    en = 1'b1; tx_ready = 1'b1;
    n = 0; cyc = 0;
    while (n < 5 && cyc < 20) begin
      if (tx_valid && tx_ready) begin void'(exp_q.pop_front()); n++; end
      tick(); cyc++;
    end
    rst = 1'b1;
    tick();
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_abort got v=%b busy=%b exp 0/0", tx_valid, busy);
    end
    rst = 1'b0;
    model_reset();
    model_push_frame(1'b0);
    tick();
    en = 1'b0;
    n = 0; cyc = 0;
    while (n < FW && cyc < 60) begin
      if (tx_valid && tx_ready) begin
        e = exp_q.pop_front();
        checks++;
        if ({tx_sob, tx_sof, tx_eof, tx_data} !== e) begin
          errors++; $display("FAIL rstmid_beat%0d got %h exp %h", n, {tx_sob, tx_sof, tx_eof, tx_data}, e);
        end
        n++;
      end
      tick(); cyc++;
    end
    tx_ready = 1'b0;
    checks++;
    if (n != FW || frames_sent !== 32'd1) begin
      errors++; $display("FAIL rstmid_done got beats=%0d frames=%0d exp %0d/1", n, frames_sent, FW);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_block_wrap();
    test_err_inj();
    test_gap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
